// File: rtl/seq_scan_ctrl.sv
// Job controller for an external serial sequence detector: clears it, streams a word MSB-first
// and collects the per-bit match mask. Optional match counter is built when SEQ_SCAN_CNT_EN is defined.
module seq_scan_ctrl #(
  parameter int WORD_W  = 32,
  parameter int PAT_W   = 4,
  parameter int DET_LAT = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [WORD_W-1:0]            req_word,
  input  logic [PAT_W-1:0]             req_pat,
  output logic                         det_res_n,
  output logic [PAT_W-1:0]             det_seq,
  output logic                         det_din,
  input  logic                         det_dout,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [WORD_W-1:0]            res_mask,
  output logic [$clog2(WORD_W+1)-1:0]  res_cnt,
  output logic                         busy
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int PH_W  = $clog2(WORD_W + DET_LAT + 1);

  // SHIFT and DRAIN share one phase counter; the capture window is its last WORD_W values.
  localparam logic [PH_W-1:0] LAST_SHIFT = PH_W'(WORD_W - 1);
  localparam logic [PH_W-1:0] LAST_DRAIN = PH_W'(WORD_W + DET_LAT - 1);
  localparam logic [PH_W-1:0] CAP_START  = PH_W'(DET_LAT);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, RESP} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [PAT_W-1:0]  seq_q, seq_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [WORD_W-1:0] mask_q, mask_d;
  logic              capture;

  assign capture = ((state_q == SHIFT) || (state_q == DRAIN)) && (phase_q >= CAP_START);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    seq_d   = seq_q;
    phase_d = phase_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          shreg_d = req_word;
          seq_d   = req_pat;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mask_d  = '0;
        phase_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
        phase_d = phase_q + PH_W'(1);
        if (phase_q == LAST_SHIFT) state_d = (DET_LAT == 0) ? RESP : DRAIN;
      end
      DRAIN: begin
        phase_d = phase_q + PH_W'(1);
        if (phase_q == LAST_DRAIN) state_d = RESP;
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture) mask_d = {mask_q[WORD_W-2:0], det_dout};
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      seq_q   <= '0;
      phase_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
    end
  end

  // NOTE: the shift register is loaded on acceptance before it is ever read, so it carries no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

`ifdef SEQ_SCAN_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == CLEAR)        cnt_d = '0;
    else if (capture && det_dout) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign res_cnt = cnt_q;
`else
  assign res_cnt = '0;
`endif

  // Reset must win over a coincident handshake, so ready is masked combinationally.
  assign req_ready = (state_q == IDLE) && !reset;
  assign det_res_n = (state_q == SHIFT) || (state_q == DRAIN);
  assign det_din   = (state_q == SHIFT) && shreg_q[WORD_W-1];
  assign det_seq   = seq_q;
  assign res_valid = (state_q == RESP);
  assign res_mask  = mask_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: two controllers (DET_LAT 1 and 2), each driving an overlapping detector stub,
// checked against an arithmetic reference of where the pattern occurs in the word.
module tb_seq_scan_ctrl;

  localparam int W  = 32;
  localparam int P  = 4;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req_valid [2];
  logic          req_ready [2];
  logic [W-1:0]  req_word  [2];
  logic [P-1:0]  req_pat   [2];
  logic          det_res_n [2];
  logic [P-1:0]  det_seq   [2];
  logic          det_din   [2];
  logic          det_dout  [2];
  logic          res_valid [2];
  logic          res_ready [2];
  logic [W-1:0]  res_mask  [2];
  logic [CW-1:0] res_cnt   [2];
  logic          busy      [2];

  for (genvar g = 0; g < 2; g++) begin : g_unit
    localparam int LAT = g + 1;

    // Overlapping detector stub: match on the last P bits seen since its reset, delayed by LAT cycles.
    logic [P-2:0]   hist = '0;
    int             fed  = 0;
    logic [LAT-1:0] pipe = '0;
    logic           hit;

    assign hit = det_res_n[g] && (fed >= P - 1) && ({hist, det_din[g]} == det_seq[g]);

    always @(posedge clk) begin
      if (!det_res_n[g]) begin
        hist <= '0;
        fed  <= 0;
      end else begin
        hist <= {hist[P-3:0], det_din[g]};
        if (fed < P) fed <= fed + 1;
      end
      pipe <= (pipe << 1) | LAT'(hit);
    end

    assign det_dout[g] = pipe[LAT-1];

    seq_scan_ctrl #(.WORD_W(W), .PAT_W(P), .DET_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_word  (req_word[g]),
      .req_pat   (req_pat[g]),
      .det_res_n (det_res_n[g]),
      .det_seq   (det_seq[g]),
      .det_din   (det_din[g]),
      .det_dout  (det_dout[g]),
      .res_valid (res_valid[g]),
      .res_ready (res_ready[g]),
      .res_mask  (res_mask[g]),
      .res_cnt   (res_cnt[g]),
      .busy      (busy[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit j is set when word[j+P-1:j] equals the pattern: the match completes as word[j] is shifted in.
  function automatic logic [W-1:0] ref_mask(input logic [W-1:0] word, input logic [P-1:0] pat);
    ref_mask = '0;
    for (int j = 0; j <= W - P; j++) begin
      if (word[j +: P] == pat) ref_mask[j] = 1'b1;
    end
  endfunction

  function automatic logic [CW-1:0] ref_cnt(input logic [W-1:0] m);
`ifdef SEQ_SCAN_CNT_EN
    ref_cnt = CW'($countones(m));
`else
    ref_cnt = m & '0;
`endif
  endfunction

  // Runs one job on unit u starting at a negedge; optionally presents the next job during RESP.
  task automatic run_job(input int u, input logic [W-1:0] word, input logic [P-1:0] pat,
                         input int hold, input bit chain,
                         input logic [W-1:0] nword, input logic [P-1:0] npat);
    logic [W-1:0] exp_m;
    int edges, din_bad, seq_bad, rn_low;
    exp_m = ref_mask(word, pat);
    req_valid[u] = 1'b1;
    req_word[u]  = word;
    req_pat[u]   = pat;
    check("req_ready_idle", req_ready[u], 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    req_word[u]  = $urandom;
    check("busy_clear", busy[u], 1'b1);
    edges = 0; din_bad = 0; seq_bad = 0; rn_low = 0;
    while (!res_valid[u] && edges < 200) begin
      if (!det_res_n[u]) rn_low++;
      if (det_seq[u] !== pat) seq_bad++;
      if (edges >= 1 && edges <= W && det_din[u] !== word[W-edges]) din_bad++;
      @(negedge clk);
      edges++;
    end
    check("res_latency", edges, W + 2 + u);
    check("res_n_low_cycles", rn_low, 1);
    check("det_seq_stable", seq_bad, 0);
    check("det_din_stream", din_bad, 0);
    if (chain) begin
      req_valid[u] = 1'b1;
      req_word[u]  = nword;
      req_pat[u]   = npat;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", res_valid[u], 1'b1);
      check("hold_mask", res_mask[u], exp_m);
      check("hold_cnt", res_cnt[u], ref_cnt(exp_m));
      check("hold_req_ready", req_ready[u], 1'b0);
      @(negedge clk);
    end
    check("res_mask", res_mask[u], exp_m);
    check("res_cnt", res_cnt[u], ref_cnt(exp_m));
    res_ready[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready[u] = 1'b0;
    check("idle_after_resp", {res_valid[u], req_ready[u], busy[u]}, 3'b010);
  endtask

  task automatic check_reset_values(input int u, input logic ready_exp);
    check("rst_req_ready", req_ready[u], ready_exp);
    check("rst_det_res_n", det_res_n[u], 1'b0);
    check("rst_det_seq", det_seq[u], '0);
    check("rst_det_din", det_din[u], 1'b0);
    check("rst_res_valid", res_valid[u], 1'b0);
    check("rst_res_mask", res_mask[u], '0);
    check("rst_res_cnt", res_cnt[u], '0);
    check("rst_busy", busy[u], 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w;
    logic [P-1:0] p;
    int seen;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_word[i]  = '0;
      req_pat[i]   = '0;
      res_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("req_ready_in_reset", req_ready[0], 1'b0);
    reset = 1'b0;
    #1;
    check_reset_values(0, 1'b1);
    check_reset_values(1, 1'b1);

    // Directed jobs from the known-answer table.
    run_job(0, 32'h4BA56BAB, 4'b1010, 0, 1'b0, '0, '0);
    check("kat1_mask", res_mask[0], 32'h00108414);
`ifdef SEQ_SCAN_CNT_EN
    check("kat1_cnt", res_cnt[0], 5);
`endif
    run_job(0, 32'h4BA56BB6, 4'b1101, 0, 1'b0, '0, '0);
    check("kat2_mask", res_mask[0], 32'h00200824);
`ifdef SEQ_SCAN_CNT_EN
    check("kat2_cnt", res_cnt[0], 4);
`endif
    run_job(0, 32'h0, 4'b0110, 2, 1'b0, '0, '0);
    check("kat3_mask", res_mask[0], 32'h0);

    // Result held for 5 cycles while the next request waits; it is taken the cycle after res_ready.
    run_job(0, 32'hA5A5F00F, 4'b0101, 5, 1'b1, 32'h13579BDF, 4'b1011);
    run_job(0, 32'h13579BDF, 4'b1011, 0, 1'b0, '0, '0);

    // Longer detector latency on the second unit.
    run_job(1, 32'h4BA56BAB, 4'b1010, 1, 1'b0, '0, '0);
    check("kat_lat2_mask", res_mask[1], 32'h00108414);

    // Reset during SHIFT bit 10 discards the job.
    w = 32'hDEADBEEF;
    req_valid[0] = 1'b1;
    req_word[0]  = w;
    req_pat[0]   = 4'b1110;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_shift_din", det_din[0], w[W-11]);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values(0, 1'b0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid[0]) seen++;
    end
    check("no_result_after_reset", seen, 0);
    run_job(0, 32'h4BA56BAB, 4'b1010, 0, 1'b0, '0, '0);

    // Reset coincident with a handshake: the job is not accepted.
    reset = 1'b1;
    req_valid[0] = 1'b1;
    req_word[0]  = 32'hFFFF0000;
    req_pat[0]   = 4'b1111;
    #1;
    check("ready_masked_by_reset", req_ready[0], 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    check("no_accept_in_reset", busy[0], 1'b0);
    check("seq_not_loaded", det_seq[0], '0);
    @(negedge clk);

    // Randomized jobs on both units.
    for (int k = 0; k < 24; k++) begin
      w = $urandom;
      if (k % 3 == 0) w = w & $urandom;
      p = P'($urandom_range(0, 15));
      run_job(k % 2, w, p, $urandom_range(0, 3), 1'b0, '0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
